// File: rtl/pirdsp_config_loader.sv
// pirdsp_config_loader: serial loader/readback/verify engine for a DSP configuration daisy chain
//   clk                  : single clock, all state updates on the rising edge
//   reset                : synchronous active-high reset
//   cfg_valid/cfg_ready  : request handshake, accepted only in IDLE
//   cfg_word             : image to load, bit i lands in chain register i (register 0 at the head)
//   cfg_verify           : request a second pass that reshifts the image and checks it
//   configuration_enable : chain shift enable, high in LOAD and VERIFY
//   configuration_input  : serial data into the chain head, MSB of the image first
//   configuration_output : serial data from the chain tail
//   busy / done          : not-IDLE flag / one-cycle completion pulse
//   readback             : chain image captured while loading, bit i = old register i
//   verify_err           : sticky mismatch flag from the verify pass
module pirdsp_config_loader #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAIN_LEN-1:0] cfg_word,
    input  logic                 cfg_verify,
    output logic                 configuration_enable,
    output logic                 configuration_input,
    input  logic                 configuration_output,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] readback,
    output logic                 verify_err
);
    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d, hold_q, hold_d, rb_q, rb_d;
    logic                 vflag_q, vflag_d, verr_q, verr_d;
    logic                 last;
    assign last = cnt_q == CNT_W'(CHAIN_LEN - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        rb_d    = rb_q;
        vflag_d = vflag_q;
        verr_d  = verr_q;
        case (state_q)
            IDLE: if (cfg_valid) begin
                state_d = LOAD;
                shift_d = cfg_word;
                hold_d  = cfg_word;
                vflag_d = cfg_verify;
                verr_d  = 1'b0;
                cnt_d   = '0;
            end
            LOAD: begin
                // the tail bit leaving the chain is the old image, MSB first
                rb_d    = CHAIN_LEN'({rb_q, configuration_output});
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                shift_d = (last && vflag_q) ? hold_q : shift_q << 1;
                state_d = last ? (vflag_q ? VERIFY : DONE) : LOAD;
            end
            VERIFY: begin
                // the bit emerging now is the one shifted in CHAIN_LEN cycles earlier,
                // which is the same image bit currently at the shift register MSB
                verr_d  = verr_q | (configuration_output != shift_q[CHAIN_LEN-1]);
                shift_d = shift_q << 1;
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = last ? DONE : VERIFY;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            rb_q    <= '0;
            vflag_q <= 1'b0;
            verr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            rb_q    <= rb_d;
            vflag_q <= vflag_d;
            verr_q  <= verr_d;
        end
    end
    assign cfg_ready            = state_q == IDLE;
    assign busy                 = state_q != IDLE;
    assign done                 = state_q == DONE;
    assign configuration_enable = (state_q == LOAD) || (state_q == VERIFY);
    assign configuration_input  = shift_q[CHAIN_LEN-1];
    assign readback             = rb_q;
    assign verify_err           = verr_q;
endmodule

// File: tb/tb_pirdsp_config_loader.sv
// tb_pirdsp_config_loader: directed scoreboard bench for the configuration chain loader
module tb_pirdsp_config_loader;
    logic       clk = 1'b0;
    logic       reset, cfg_valid, cfg_verify;
    logic [3:0] cfg_word;
    logic       cfg_ready, configuration_enable, configuration_input, configuration_output;
    logic       busy, done, verify_err;
    logic [3:0] readback;
    logic [3:0] chain = 4'b0000;
    logic       stuck = 1'b0;

    typedef struct {
        int         lat;
        logic [3:0] rb;
        logic       verr;
        logic [3:0] img;
    } res_t;

    res_t res_q[$];
    logic bits_q[$];
    int   acc_q[$];
    int   errors = 0, checks = 0, cyc = 0, n_done = 0, n_acc = 0;

    pirdsp_config_loader #(.CHAIN_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_word(cfg_word), .cfg_verify(cfg_verify),
        .configuration_enable(configuration_enable), .configuration_input(configuration_input),
        .configuration_output(configuration_output), .busy(busy), .done(done),
        .readback(readback), .verify_err(verify_err));

    always #5 clk = ~clk;

    // chain model: register 0 at the head, tail drives configuration_output; optional stuck-at-1 on register 2
    always @(posedge clk)
        if (configuration_enable) chain <= {chain[2:0], configuration_input} | (stuck ? 4'b0100 : 4'b0000);
    assign configuration_output = chain[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc;
        res_t r;
        int a;
        acc = cfg_valid && cfg_ready && !reset;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            acc_q.push_back(cyc - 1);
            n_acc++;
        end
        if (configuration_enable) begin
            chk("shift_expected", 32'(bits_q.size() > 0), 1);
            if (bits_q.size() > 0) chk("cfg_in", configuration_input, bits_q.pop_front());
        end
        if (done) begin
            n_done++;
            chk("result_expected", 32'(res_q.size() > 0 && acc_q.size() > 0), 1);
            if (res_q.size() > 0 && acc_q.size() > 0) begin
                r = res_q.pop_front();
                a = acc_q.pop_front();
                chk("latency", cyc - a, r.lat);
                chk("readback", readback, r.rb);
                chk("verify_err", verify_err, r.verr);
                chk("chain", chain, r.img);
            end
        end
    endtask

    task automatic push_bits(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) bits_q.push_back(w[i]);
    endtask

    task automatic push_req(input logic [3:0] w, input logic v, input logic [3:0] rb, input logic verr, input logic [3:0] img);
        push_bits(w);
        if (v) push_bits(w);
        res_q.push_back('{v ? 9 : 5, rb, verr, img});
    endtask

    task automatic wait_done(input int bound);
        int d0;
        d0 = n_done;
        for (int i = 0; i < bound && n_done == d0; i++) tick();
        chk("done_seen", n_done - d0, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_ready", cfg_ready, 1);
        chk("bits_consumed", bits_q.size(), 0);
    endtask

    initial begin
        int d0, a0;
        reset = 1'b1; cfg_valid = 1'b0; cfg_word = 4'b0000; cfg_verify = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enable", configuration_enable, 0);
        chk("rst_readback", readback, 4'b0000);
        chk("rst_verr", verify_err, 0);

        push_req(4'b1011, 1'b0, 4'b0000, 1'b0, 4'b1011);
        cfg_word = 4'b1011; cfg_verify = 1'b0; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("load_busy", busy, 1);
        wait_done(20);

        push_req(4'b0110, 1'b1, 4'b1011, 1'b0, 4'b0110);
        cfg_word = 4'b0110; cfg_verify = 1'b1; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_done(20);

        // stuck register 2 corrupts both the captured image and the reshifted one
        stuck = 1'b1;
        push_req(4'b0000, 1'b1, 4'b0111, 1'b1, 4'b1100);
        cfg_word = 4'b0000; cfg_verify = 1'b1; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_done(20);
        tick(); tick(); tick();
        chk("verr_sticky", verify_err, 1);
        chk("rb_stable", readback, 4'b0111);
        stuck = 1'b0;

        push_bits(4'b1010);
        cfg_word = 4'b1010; cfg_verify = 1'b0; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("accept_clears_verr", verify_err, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_enable", configuration_enable, 0);
        chk("abort_ready", cfg_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_verr", verify_err, 0);
        d0 = n_done;
        repeat (6) tick();
        chk("abort_no_done", n_done - d0, 0);
        bits_q.delete();
        acc_q.delete();

        reset = 1'b1; cfg_valid = 1'b1;
        tick();
        reset = 1'b0; cfg_valid = 1'b0;
        chk("reset_over_accept", busy, 0);
        tick();
        chk("no_late_accept", busy, 0);

        push_req(4'b0101, 1'b0, chain, 1'b0, 4'b0101);
        push_req(4'b0101, 1'b0, 4'b0101, 1'b0, 4'b0101);
        d0 = n_done; a0 = n_acc;
        cfg_word = 4'b0101; cfg_verify = 1'b0; cfg_valid = 1'b1;
        repeat (12) tick();
        cfg_valid = 1'b0;
        repeat (3) tick();
        chk("held_accepts", n_acc - a0, 2);
        chk("held_dones", n_done - d0, 2);
        chk("held_bits", bits_q.size(), 0);
        chk("held_results", res_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
